comparator_serial_n: RTL and testbench

//   Parametrised multi-cycle magnitude comparator, next generation of the

---
 rtl/comparator_serial_n.sv | 121 ++++++++++++
 tb/tb_comparator_serial_n.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial_n.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per clock,
// MSB chunk first, stopping at the first differing chunk. Signed mode flips
// the operand MSBs so a plain unsigned chunk compare orders two's-complement
// values correctly.
module comparator_serial_n #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             greater,
   output logic             less,
   output logic             equal
);

   localparam int unsigned N    = WIDTH / DIGIT;
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  op_a;
   logic [WIDTH-1:0]  op_b;
   logic [IDXW-1:0]   idx;
   logic [DIGIT-1:0]  chunk_a;
   logic [DIGIT-1:0]  chunk_b;
   logic              chunk_gt;
   logic              chunk_lt;
   logic              last_chunk;
   logic              load;
   logic              advance;
   logic              result_wr;

   // Operands are shifted left each cycle, so the active chunk is always on top.
   assign chunk_a    = op_a[WIDTH-1 -: DIGIT];
   assign chunk_b    = op_b[WIDTH-1 -: DIGIT];
   assign chunk_gt   = (chunk_a > chunk_b);
   assign chunk_lt   = (chunk_a < chunk_b);
   assign last_chunk = (idx == IDXW'(N - 1));

   assign busy = (state == COMPARE);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      result_wr = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = COMPARE;
            end
         end
         COMPARE: begin
            if (chunk_gt || chunk_lt || last_chunk) begin
               result_wr = 1'b1;
               state_nxt = DONE;
            end else begin
               advance = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand shift registers, chunk index and held result flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a    <= '0;
         op_b    <= '0;
         idx     <= '0;
         greater <= 1'b0;
         less    <= 1'b0;
         equal   <= 1'b0;
      end else begin
         if (load) begin
            op_a <= a ^ (WIDTH'(signed_mode) << (WIDTH - 1));
            op_b <= b ^ (WIDTH'(signed_mode) << (WIDTH - 1));
            idx  <= '0;
         end else if (advance) begin
            op_a <= WIDTH'({op_a, {DIGIT{1'b0}}});
            op_b <= WIDTH'({op_b, {DIGIT{1'b0}}});
            idx  <= idx + IDXW'(1);
         end
         if (result_wr) begin
            greater <= chunk_gt;
            less    <= chunk_lt;
            equal   <= ~chunk_gt & ~chunk_lt;
         end
      end
   end

endmodule

// File: tb/tb_comparator_serial_n.sv
// Directed bench for comparator_serial_n: hand-computed vectors on the 8/2
// configuration plus random sweeps on the 16/1 and 8/8 configurations.
module tb_comparator_serial_n;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // 8-bit, 2-bit digit instance
   logic       start, sm, busy, done, gt, lt, eq;
   logic [7:0] a, b;
   // 16-bit, 1-bit digit instance
   logic        s_start, s_sm, s_busy, s_done, s_gt, s_lt, s_eq;
   logic [15:0] s_a, s_b;
   // 8-bit, 8-bit digit instance
   logic       t_start, t_sm, t_busy, t_done, t_gt, t_lt, t_eq;
   logic [7:0] t_a, t_b;

   comparator_serial_n #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .reset(reset), .start(start), .signed_mode(sm), .a(a), .b(b),
      .busy(busy), .done(done), .greater(gt), .less(lt), .equal(eq));

   comparator_serial_n #(.WIDTH(16), .DIGIT(1)) dut16 (
      .clk(clk), .reset(reset), .start(s_start), .signed_mode(s_sm), .a(s_a), .b(s_b),
      .busy(s_busy), .done(s_done), .greater(s_gt), .less(s_lt), .equal(s_eq));

   comparator_serial_n #(.WIDTH(8), .DIGIT(8)) dut88 (
      .clk(clk), .reset(reset), .start(t_start), .signed_mode(t_sm), .a(t_a), .b(t_b),
      .busy(t_busy), .done(t_done), .greater(t_gt), .less(t_lt), .equal(t_eq));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a request on the main instance; returns in cycle 1.
   task automatic go8(input logic [7:0] va, input logic [7:0] vb, input logic vs);
      a = va; b = vb; sm = vs; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // From cycle 1, advance until done (bounded); returns the cycle number seen.
   task automatic wait8(output int cyc);
      cyc = 1;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_vec++;
      if ({busy, done, gt, lt, eq} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset8: got %b want 00000", {busy, done, gt, lt, eq});
      end
      n_vec++;
      if ({s_busy, s_done, s_gt, s_lt, s_eq, t_busy, t_done, t_gt, t_lt, t_eq} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_sweep: got %b want 0",
                  {s_busy, s_done, s_gt, s_lt, s_eq, t_busy, t_done, t_gt, t_lt, t_eq});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_equal();
      go8(8'h00, 8'h00, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         n_vec++;
         if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL equal_busy c%0d: busy,done=%b want 10", c, {busy, done});
         end
         tick();
      end
      n_vec++;
      if ({busy, done, gt, lt, eq} !== 5'b01001) begin
         n_fail++;
         $display("FAIL equal_done c5: got %b want 01001", {busy, done, gt, lt, eq});
      end
      tick();
      n_vec++;
      if ({busy, done, gt, lt, eq} !== 5'b00001) begin
         n_fail++;
         $display("FAIL equal_hold c6: got %b want 00001", {busy, done, gt, lt, eq});
      end
   endtask

   task automatic test_vectors();
      logic [7:0] va[6]  = '{8'h80, 8'h80, 8'h0F, 8'hFC, 8'h1C, 8'h7F};
      logic [7:0] vb[6]  = '{8'h01, 8'h01, 8'h70, 8'hA0, 8'h1D, 8'h80};
      logic       vs[6]  = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
      logic [2:0] res[6] = '{3'b100, 3'b010, 3'b010, 3'b100, 3'b010, 3'b100};
      int         lat[6] = '{2, 2, 2, 2, 5, 2};
      int cyc;
      for (int i = 0; i < 6; i++) begin
         go8(va[i], vb[i], vs[i]);
         wait8(cyc);
         n_vec++;
         if (cyc != lat[i]) begin
            n_fail++;
            $display("FAIL vec%0d_latency: done in cycle %0d want %0d", i, cyc, lat[i]);
         end
         n_vec++;
         if ({gt, lt, eq} !== res[i]) begin
            n_fail++;
            $display("FAIL vec%0d_result: gle=%b want %b", i, {gt, lt, eq}, res[i]);
         end
         tick();
      end
   endtask

   task automatic test_start_while_busy();
      int pulses = 0;
      go8(8'h00, 8'h00, 1'b0);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      if (done) pulses++;
      tick();
      a = 8'h00; b = 8'hFF; sm = 1'b1;
      if (done) pulses++;
      tick();
      start = 1'b0;
      for (int c = 3; c <= 9; c++) begin
         if (done) pulses++;
         if (c == 5) begin
            n_vec++;
            if ({done, gt, lt, eq} !== 4'b1001) begin
               n_fail++;
               $display("FAIL busy_start_done: got %b want 1001", {done, gt, lt, eq});
            end
         end
         tick();
      end
      n_vec++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL busy_start_pulses: got %0d want 1", pulses);
      end
      n_vec++;
      if ({busy, gt, lt, eq} !== 4'b0001) begin
         n_fail++;
         $display("FAIL busy_start_hold: got %b want 0001", {busy, gt, lt, eq});
      end
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      int cyc;
      go8(8'h1C, 8'h1D, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if ({busy, done, gt, lt, eq} !== 5'b0) begin
         n_fail++;
         $display("FAIL abort_state: got %b want 00000", {busy, done, gt, lt, eq});
      end
      for (int c = 0; c < 6; c++) begin
         if (done || busy) pulses++;
         tick();
      end
      n_vec++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: activity %0d cycles want 0", pulses);
      end
      go8(8'h1C, 8'h1D, 1'b0);
      wait8(cyc);
      n_vec++;
      if (cyc != 5 || {gt, lt, eq} !== 3'b010) begin
         n_fail++;
         $display("FAIL abort_restart: cycle %0d gle=%b want 5 010", cyc, {gt, lt, eq});
      end
      tick();
   endtask

   task automatic test_sweep_w16_d1();
      logic [15:0] x;
      logic [2:0]  exp_r;
      int cyc, k;
      for (int i = 0; i < 1000; i++) begin
         s_a = 16'($urandom);
         s_b = (i % 6 == 0) ? s_a : ((i % 6 == 1) ? s_a ^ 16'(1 << (i % 16)) : 16'($urandom));
         s_sm = 1'($urandom_range(0, 1));
         s_start = 1'b1;
         tick();
         s_start = 1'b0;
         cyc = 1;
         while (!s_done && cyc < 40) begin
            tick();
            cyc++;
         end
         x = s_a ^ s_b;
         k = 15;
         for (int j = 15; j >= 0; j--) begin
            if (x[j]) begin
               k = 15 - j;
               break;
            end
         end
         if (s_sm) exp_r = {$signed(s_a) > $signed(s_b), $signed(s_a) < $signed(s_b), s_a == s_b};
         else      exp_r = {s_a > s_b, s_a < s_b, s_a == s_b};
         n_vec++;
         if (cyc != k + 2 || {s_gt, s_lt, s_eq} !== exp_r) begin
            n_fail++;
            $display("FAIL sweep16 a=%h b=%h s=%0d: cycle %0d gle=%b want %0d %b",
                     s_a, s_b, s_sm, cyc, {s_gt, s_lt, s_eq}, k + 2, exp_r);
         end
         tick();
      end
   endtask

   task automatic test_sweep_w8_d8();
      logic [2:0] exp_r;
      int cyc;
      for (int i = 0; i < 1000; i++) begin
         t_a = 8'($urandom);
         t_b = (i % 5 == 0) ? t_a : 8'($urandom);
         t_sm = 1'($urandom_range(0, 1));
         t_start = 1'b1;
         tick();
         t_start = 1'b0;
         cyc = 1;
         while (!t_done && cyc < 40) begin
            tick();
            cyc++;
         end
         if (t_sm) exp_r = {$signed(t_a) > $signed(t_b), $signed(t_a) < $signed(t_b), t_a == t_b};
         else      exp_r = {t_a > t_b, t_a < t_b, t_a == t_b};
         n_vec++;
         if (cyc != 2 || {t_gt, t_lt, t_eq} !== exp_r) begin
            n_fail++;
            $display("FAIL sweep8 a=%h b=%h s=%0d: cycle %0d gle=%b want 2 %b",
                     t_a, t_b, t_sm, cyc, {t_gt, t_lt, t_eq}, exp_r);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; sm = 1'b0; a = '0; b = '0;
      s_start = 1'b0; s_sm = 1'b0; s_a = '0; s_b = '0;
      t_start = 1'b0; t_sm = 1'b0; t_a = '0; t_b = '0;
      test_reset();
      test_equal();
      test_vectors();
      test_start_while_busy();
      test_reset_abort();
      test_sweep_w16_d1();
      test_sweep_w8_d8();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
